seq_detector_prog: RTL and testbench

Parametrised, run-time programmable serial bit-pattern detector. It is the generalised successor to the fixed 1011 detector: the pattern width is set at elaboration, the pattern value is loaded at run time, and the input stream is qualified by a valid strobe. Overlapping or non-overlapping match mode is selectable, and an optional saturating match counter is provided. It sits on the serial test/stimulus path and flags pattern occurrences to the control logic.

---
 rtl/seq_detector_prog_if.sv | 25 ++
 rtl/seq_detector_prog.sv | 111 +++++++++++
 tb/tb_seq_detector_prog.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detector_prog_if.sv
// Bus bundle for seq_detector_prog: pattern load, serial stream and match outputs.
// The master drives the stream; the slave is the detector.
interface seq_detector_prog_if #(
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 8
);
  logic               pattern_load;
  logic [SEQ_LEN-1:0] pattern;
  logic               overlap_en;
  logic               in_valid;
  logic               inp_bit;
  logic               seq_seen;
  logic [CNT_W-1:0]   match_count;
  logic               armed;

  modport master (
    output pattern_load, pattern, overlap_en, in_valid, inp_bit,
    input  seq_seen, match_count, armed
  );

  modport slave (
    input  pattern_load, pattern, overlap_en, in_valid, inp_bit,
    output seq_seen, match_count, armed
  );
endinterface

// File: rtl/seq_detector_prog.sv
// Run-time programmable serial pattern detector with overlap control.
// Define SEQ_DET_MATCH_CNT_EN to build the saturating match counter; otherwise match_count is 0.
module seq_detector_prog #(
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 8
) (
  input logic                 clk,
  input logic                 reset,
  seq_detector_prog_if.slave  bus
);
  localparam int FW = $clog2(SEQ_LEN + 1);

  typedef enum logic [1:0] {UNLOADED, FILL, MATCH} state_t;

  state_t             state_q, state_d;
  logic [SEQ_LEN-1:0] pat_q, hist_q, hist_d, hist_shift;
  logic [FW-1:0]      fill_q, fill_d;
  logic               seen_q, seen_d;
  logic               armed_q;
  logic               pat_we;
  logic               full_next;
  logic               match;

  assign hist_shift = {hist_q[SEQ_LEN-2:0], bus.inp_bit};
  // History is full after this bit either because it already was, or this bit completes it.
  assign full_next  = (state_q == MATCH) ||
                      ((state_q == FILL) && (fill_q == FW'(SEQ_LEN - 1)));
  assign match      = bus.in_valid && full_next && (hist_shift == pat_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UNLOADED;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      seen_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      seen_q  <= seen_d;
      if (pat_we) begin
        pat_q   <= bus.pattern;
        armed_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    seen_d  = 1'b0;
    pat_we  = 1'b0;
    case (state_q)
      UNLOADED: begin
        if (bus.pattern_load) begin
          pat_we  = 1'b1;
          hist_d  = '0;
          fill_d  = '0;
          state_d = FILL;
        end
      end
      FILL, MATCH: begin
        if (bus.pattern_load) begin
          // A reload discards any bit or match arriving in the same cycle.
          pat_we  = 1'b1;
          hist_d  = '0;
          fill_d  = '0;
          state_d = FILL;
        end else if (bus.in_valid) begin
          hist_d = hist_shift;
          if (state_q == FILL) begin
            fill_d = fill_q + 1'b1;
            if (fill_q == FW'(SEQ_LEN - 1)) state_d = MATCH;
          end
          if (match) begin
            seen_d = 1'b1;
            if (!bus.overlap_en) begin
              hist_d  = '0;
              fill_d  = '0;
              state_d = FILL;
            end
          end
        end
      end
      default: state_d = UNLOADED;
    endcase
  end

  assign bus.seq_seen = seen_q;
  assign bus.armed    = armed_q;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (pat_we)
      cnt_q <= '0;
    else if (seen_d && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.match_count = cnt_q;
`else
  assign bus.match_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: two detectors (8-bit and 2-bit counters) share one stream
// and are compared every cycle against a queue-based model, plus hand-computed checkpoints.
module tb_seq_detector_prog;
  localparam int SEQ_LEN = 4;

  logic               clk;
  logic               reset;
  logic               pattern_load;
  logic [SEQ_LEN-1:0] pattern;
  logic               overlap_en;
  logic               in_valid;
  logic               inp_bit;

  int checks = 0;
  int errors = 0;

  seq_detector_prog_if #(.SEQ_LEN(SEQ_LEN), .CNT_W(8)) bus_a ();
  seq_detector_prog_if #(.SEQ_LEN(SEQ_LEN), .CNT_W(2)) bus_b ();

  assign bus_a.pattern_load = pattern_load;
  assign bus_a.pattern      = pattern;
  assign bus_a.overlap_en   = overlap_en;
  assign bus_a.in_valid     = in_valid;
  assign bus_a.inp_bit      = inp_bit;
  assign bus_b.pattern_load = pattern_load;
  assign bus_b.pattern      = pattern;
  assign bus_b.overlap_en   = overlap_en;
  assign bus_b.in_valid     = in_valid;
  assign bus_b.inp_bit      = inp_bit;

  seq_detector_prog #(.SEQ_LEN(SEQ_LEN), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  seq_detector_prog #(.SEQ_LEN(SEQ_LEN), .CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int exp_cnt(input int n, input int w);
`ifdef SEQ_DET_MATCH_CNT_EN
    int lim;
    lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: keeps the accepted bits since the last clear and matches the newest SEQ_LEN of them.
  bit                 started = 0;
  bit                 m_loaded;
  bit [SEQ_LEN-1:0]   m_pat;
  bit                 m_hist[$];
  bit                 m_seen;
  bit                 m_armed;
  int                 m_cnt;
  int                 m_pulses = 0;

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      m_loaded = 0; m_pat = '0; m_hist.delete();
      m_seen = 0; m_armed = 0; m_cnt = 0;
    end else begin
      m_seen = 0;
      if (pattern_load) begin
        m_loaded = 1; m_armed = 1; m_pat = pattern; m_hist.delete(); m_cnt = 0;
      end else if (m_loaded && in_valid) begin
        bit hit;
        m_hist.push_back(inp_bit);
        if (m_hist.size() > SEQ_LEN) void'(m_hist.pop_front());
        if (m_hist.size() == SEQ_LEN) begin
          hit = 1;
          for (int i = 0; i < SEQ_LEN; i++)
            if (m_hist[i] != m_pat[SEQ_LEN-1-i]) hit = 0;
          if (hit) begin
            m_seen = 1;
            m_cnt++;
            m_pulses++;
            if (!overlap_en) m_hist.delete();
          end
        end
      end
    end
  end

  int dut_pulses = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("seq_seen_a", int'(bus_a.seq_seen), int'(m_seen));
      chk("seq_seen_b", int'(bus_b.seq_seen), int'(m_seen));
      chk("armed_a", int'(bus_a.armed), int'(m_armed));
      chk("count_a", int'(bus_a.match_count), exp_cnt(m_cnt, 8));
      chk("count_b", int'(bus_b.match_count), exp_cnt(m_cnt, 2));
      if (bus_a.seq_seen) dut_pulses++;
    end
  end

  task automatic step(input logic ld, input logic [SEQ_LEN-1:0] p, input logic v, input logic b);
    pattern_load = ld;
    pattern      = p;
    in_valid     = v;
    inp_bit      = b;
    @(posedge clk);
    #1;
    pattern_load = 1'b0;
    in_valid     = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, pattern, 1'b1, bits[i]);
  endtask

  task automatic load(input logic [SEQ_LEN-1:0] p, input logic ov);
    overlap_en = ov;
    step(1'b1, p, 1'b0, 1'b0);
  endtask

  int d0, m0;

  task automatic mark();
    d0 = dut_pulses;
    m0 = m_pulses;
  endtask

  task automatic pulses_are(input string name, input int n);
    chk({name, "_dut_pulses"}, dut_pulses - d0, n);
    chk({name, "_model_pulses"}, m_pulses - m0, n);
  endtask

  initial begin
    reset = 1'b1; pattern_load = 1'b0; pattern = '0;
    overlap_en = 1'b1; in_valid = 1'b0; inp_bit = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("reset_seq_seen", int'(bus_a.seq_seen), 0);
    chk("reset_armed", int'(bus_a.armed), 0);
    chk("reset_count", int'(bus_a.match_count), 0);

    // Bits before any load are ignored.
    mark();
    send_bits(16'b1011, 4);
    step(1'b0, pattern, 1'b0, 1'b0);
    pulses_are("unloaded", 0);
    chk("unloaded_armed", int'(bus_a.armed), 0);

    // Overlap: 1011011 matches after bit 4 and bit 7.
    load(4'b1011, 1'b1);
    chk("armed_after_load", int'(bus_a.armed), 1);
    mark();
    send_bits(16'b1011, 4);
    chk("overlap_pulse_bit4", int'(bus_a.seq_seen), 1);
    send_bits(16'b011, 3);
    chk("overlap_pulse_bit7", int'(bus_a.seq_seen), 1);
    step(1'b0, pattern, 1'b0, 1'b0);
    pulses_are("overlap", 2);
    chk("overlap_count", int'(bus_a.match_count), exp_cnt(2, 8));

    // Non-overlap: same stream, only the first match.
    load(4'b1011, 1'b0);
    chk("load_clears_count", int'(bus_a.match_count), 0);
    mark();
    send_bits(16'b1011011, 7);
    step(1'b0, pattern, 1'b0, 1'b0);
    pulses_are("nonoverlap", 1);
    chk("nonoverlap_count", int'(bus_a.match_count), exp_cnt(1, 8));

    // Valid gaps with a toggling data line while invalid.
    load(4'b1011, 1'b0);
    mark();
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] v;
      v = 4'b1011;
      step(1'b0, pattern, 1'b1, v[i]);
      if (i == 0) chk("gap_pulse_after_4th", int'(bus_a.seq_seen), 1);
      for (int g = 0; g < 3; g++) step(1'b0, pattern, 1'b0, ~inp_bit);
    end
    pulses_are("gaps", 1);

    // Reload mid-stream discards the partial history.
    load(4'b1011, 1'b0);
    mark();
    send_bits(16'b101, 3);
    step(1'b1, 4'b0110, 1'b1, 1'b1);
    send_bits(16'b0110, 4);
    step(1'b0, pattern, 1'b0, 1'b0);
    pulses_are("reload", 1);
    chk("reload_count", int'(bus_a.match_count), exp_cnt(1, 8));

    // Saturation: 9 ones against 1111 gives 6 back-to-back pulses.
    load(4'b1111, 1'b1);
    mark();
    send_bits(16'b111111111, 9);
    step(1'b0, pattern, 1'b0, 1'b0);
    pulses_are("saturate", 6);
    chk("saturate_count_w8", int'(bus_a.match_count), exp_cnt(6, 8));
    chk("saturate_count_w2", int'(bus_b.match_count), exp_cnt(6, 2));

    // Reset mid-stream, asserted together with a load, wipes everything.
    load(4'b1011, 1'b1);
    mark();
    send_bits(16'b101, 3);
    reset = 1'b1;
    step(1'b1, 4'b1011, 1'b1, 1'b1);
    reset = 1'b0;
    send_bits(16'b1, 1);
    step(1'b0, pattern, 1'b0, 1'b0);
    pulses_are("midreset", 0);
    chk("midreset_armed", int'(bus_a.armed), 0);
    chk("midreset_count", int'(bus_a.match_count), 0);
    chk("midreset_seq_seen", int'(bus_a.seq_seen), 0);

    step(1'b0, pattern, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
